// File: rtl/rsa_top.sv
// Iterative RSA encryptor: MSB-first message reduction mod n, then LSB-first square-and-multiply.
// Optional macro RSA_TOP_ERR_EN adds output err, flagging a captured modulus below 2.
module rsa_top #(
    parameter int unsigned MSG_W = 65,
    parameter int unsigned PQ_W  = 4,
    parameter int unsigned E_W   = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [MSG_W-1:0] message,
    input  logic [PQ_W-1:0]  p,
    input  logic [PQ_W-1:0]  q,
    input  logic [E_W-1:0]   e,
    output logic [MSG_W-1:0] encrypted_message,
    output logic             done
`ifdef RSA_TOP_ERR_EN
    ,
    output logic             err
`endif
);

    localparam int unsigned NW = 2 * PQ_W;
    localparam int unsigned MAXW = (MSG_W > E_W) ? MSG_W : E_W;
    localparam int unsigned CW = $clog2(MAXW + 1);

    typedef enum logic [1:0] {StLoad, StReduce, StExp, StDone} state_e;

    state_e           state_q, state_d;
    logic [MSG_W-1:0] msg_q, msg_d;
    logic [PQ_W-1:0]  p_q, p_d, q_q, q_d;
    logic [E_W-1:0]   e_q, e_d;
    logic [MSG_W-1:0] msh_q, msh_d;
    logic [E_W-1:0]   esh_q, esh_d;
    logic [NW-1:0]    n_q, n_d;
    logic [NW-1:0]    r_q, r_d;
    logic [NW-1:0]    acc_q, acc_d;
    logic [NW-1:0]    base_q, base_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [MSG_W-1:0] enc_q, enc_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic [NW:0]      r2;
    logic [NW-1:0]    acc_nxt;
    logic             n_small;
    logic             changed;

    // A zero modulus yields 0 so the product reduction never divides by zero.
    function automatic logic [NW-1:0] mulmod(input logic [NW-1:0] a, input logic [NW-1:0] b,
                                             input logic [NW-1:0] n);
        logic [2*NW-1:0] prod;
        logic [2*NW-1:0] rem;
        prod = (2*NW)'(a) * (2*NW)'(b);
        if (n == '0) begin
            rem = '0;
        end else begin
            rem = prod % (2*NW)'(n);
        end
        return rem[NW-1:0];
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StLoad;
            msg_q   <= '0;
            p_q     <= '0;
            q_q     <= '0;
            e_q     <= '0;
            msh_q   <= '0;
            esh_q   <= '0;
            n_q     <= '0;
            r_q     <= '0;
            acc_q   <= '0;
            base_q  <= '0;
            cnt_q   <= '0;
            enc_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            msg_q   <= msg_d;
            p_q     <= p_d;
            q_q     <= q_d;
            e_q     <= e_d;
            msh_q   <= msh_d;
            esh_q   <= esh_d;
            n_q     <= n_d;
            r_q     <= r_d;
            acc_q   <= acc_d;
            base_q  <= base_d;
            cnt_q   <= cnt_d;
            enc_q   <= enc_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        msg_d   = msg_q;
        p_d     = p_q;
        q_d     = q_q;
        e_d     = e_q;
        msh_d   = msh_q;
        esh_d   = esh_q;
        n_d     = n_q;
        r_d     = r_q;
        acc_d   = acc_q;
        base_d  = base_q;
        cnt_d   = cnt_q;
        enc_d   = enc_q;
        done_d  = done_q;
        err_d   = err_q;

        n_small = (n_q < NW'(2));
        changed = (message != msg_q) || (p != p_q) || (q != q_q) || (e != e_q);
        r2      = {r_q, msh_q[MSG_W-1]};
        if (r2 >= {1'b0, n_q}) begin
            r2 = r2 - {1'b0, n_q};
        end
        acc_nxt = esh_q[0] ? mulmod(acc_q, base_q, n_q) : acc_q;

        unique case (state_q)
            StLoad: begin
                msg_d   = message;
                p_d     = p;
                q_d     = q;
                e_d     = e;
                msh_d   = message;
                esh_d   = e;
                n_d     = NW'(p) * NW'(q);
                r_d     = '0;
                cnt_d   = '0;
                state_d = StReduce;
            end
            StReduce: begin
                r_d   = r2[NW-1:0];
                msh_d = msh_q << 1;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(MSG_W - 1)) begin
                    acc_d   = n_small ? '0 : NW'(1);
                    base_d  = r2[NW-1:0];
                    cnt_d   = '0;
                    state_d = StExp;
                end
            end
            StExp: begin
                acc_d  = acc_nxt;
                base_d = mulmod(base_q, base_q, n_q);
                esh_d  = esh_q >> 1;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(E_W - 1)) begin
                    enc_d   = n_small ? '0 : MSG_W'(acc_nxt);
                    done_d  = 1'b1;
                    err_d   = n_small;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (changed) begin
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    state_d = StLoad;
                end
            end
            default: state_d = StLoad;
        endcase
    end

    assign encrypted_message = enc_q;
    assign done              = done_q;
`ifdef RSA_TOP_ERR_EN
    assign err               = err_q;
`else
    logic unused_err;
    assign unused_err = err_q;
`endif

endmodule

// File: tb/tb_rsa_top.sv
// Scoreboard bench for rsa_top: stimulus queues expected results, a monitor checks each done pulse.
module tb_rsa_top;

    localparam int MSG_W = 65;
    localparam int PQ_W  = 4;
    localparam int E_W   = 9;

    typedef struct {
        logic [MSG_W-1:0] enc;
        logic             err;
    } exp_t;

    logic             clk;
    logic             rst;
    logic [MSG_W-1:0] message;
    logic [PQ_W-1:0]  p;
    logic [PQ_W-1:0]  q;
    logic [E_W-1:0]   e;
    logic [MSG_W-1:0] encrypted_message;
    logic             done;
`ifdef RSA_TOP_ERR_EN
    logic             err;
`endif

    exp_t sb[$];
    int   n_vec   = 0;
    int   n_miss  = 0;
    int   results = 0;
    int   lat     = 0;
    logic seen    = 1'b0;

    rsa_top #(.MSG_W(MSG_W), .PQ_W(PQ_W), .E_W(E_W)) dut (
        .clk               (clk),
        .rst               (rst),
        .message           (message),
        .p                 (p),
        .q                 (q),
        .e                 (e),
        .encrypted_message (encrypted_message),
        .done              (done)
`ifdef RSA_TOP_ERR_EN
        ,
        .err               (err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [MSG_W-1:0] act, input logic [MSG_W-1:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Edges spent with done low since the last result or reset.
    always @(posedge clk) begin
        if (rst || done) lat = 0;
        else lat = lat + 1;
    end

    always @(negedge clk) begin
        if (!rst && done && !seen) begin
            seen = 1'b1;
            results++;
            if (sb.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL unexpected_done: got result %0d, expected none", encrypted_message);
            end else begin
                exp_t x;
                x = sb.pop_front();
                chk($sformatf("result%0d", results), encrypted_message, x.enc);
                chk($sformatf("latency%0d", results), MSG_W'(lat), MSG_W'(75));
`ifdef RSA_TOP_ERR_EN
                chk($sformatf("err%0d", results), MSG_W'(err), MSG_W'(x.err));
`endif
            end
        end
        if (!done) seen = 1'b0;
    end

    task automatic push(input logic [MSG_W-1:0] enc, input logic er);
        exp_t x;
        x.enc = enc;
        x.err = er;
        sb.push_back(x);
    endtask

    task automatic drive(input logic [MSG_W-1:0] m, input int pp, input int qq, input int ee);
        @(negedge clk);
        message = m;
        p       = PQ_W'(pp);
        q       = PQ_W'(qq);
        e       = E_W'(ee);
    endtask

    task automatic wait_results(input int target);
        int k;
        k = 0;
        while (results < target && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (results < target) begin
            n_vec++;
            n_miss++;
            $display("FAIL timeout: got %0d results, expected %0d", results, target);
        end
    endtask

    initial begin
        rst     = 1'b1;
        message = 65'd81799572057445;
        p       = 4'd3;
        q       = 4'd7;
        e       = 9'd5;
        push(65'd16, 1'b0);
        #1;
        chk("reset_done", MSG_W'(done), '0);
        chk("reset_enc", encrypted_message, '0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        wait_results(1);

        drive(65'd9, 11, 13, 7);   push(65'd48, 1'b0); wait_results(2);
        drive(65'd2, 3, 11, 0);    push(65'd1, 1'b0);  wait_results(3);
        drive(65'd2, 3, 11, 3);    push(65'd8, 1'b0);
        @(posedge clk);
        #1;
        chk("done_drop", MSG_W'(done), '0);
        chk("hold_enc", encrypted_message, 65'd1);
        wait_results(4);
        drive(65'd12345, 0, 7, 5); push(65'd0, 1'b1);  wait_results(5);
        drive(65'd5, 1, 1, 3);     push(65'd0, 1'b1);  wait_results(6);
        drive(65'd21, 3, 7, 5);    push(65'd0, 1'b0);  wait_results(7);
        drive(65'd10, 5, 7, 3);    push(65'd20, 1'b0); wait_results(8);
        drive(65'd2, 3, 5, 511);   push(65'd8, 1'b0);  wait_results(9);
        drive(65'd2, 15, 15, 8);   push(65'd31, 1'b0); wait_results(10);

        // Abort during REDUCE; the result only arrives after a fresh start.
        drive(65'd9, 11, 13, 7);
        repeat (20) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_done", MSG_W'(done), '0);
        chk("abort_enc", encrypted_message, '0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        push(65'd48, 1'b0);
        wait_results(11);

        // Message changes mid-EXP: old result first, then recomputation.
        drive(65'd10, 5, 7, 3);
        push(65'd20, 1'b0);
        repeat (70) @(negedge clk);
        message = 65'd11;
        push(65'd1, 1'b0);
        wait_results(13);

        chk("queue_empty", MSG_W'(sb.size()), '0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/rsa_top.md
RSA_TOP -- requirements
Module: rsa_top

Interface
REQ-001 SHALL have parameter MSG_W, default 65, giving the message and ciphertext width.
REQ-002 SHALL have parameter PQ_W, default 4, giving the width of each prime.
REQ-003 SHALL have parameter E_W, default 9, giving the public exponent width.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 message  input  MSG_W  plaintext, unsigned integer.
REQ-007 p  input  PQ_W  prime p, unsigned.
REQ-008 q  input  PQ_W  prime q, unsigned.
REQ-009 e  input  E_W  public exponent, unsigned.
REQ-010 encrypted_message  output  MSG_W  ciphertext; zero-extended from the 2*PQ_W-bit result.
REQ-011 done  output  1  high while encrypted_message holds the result for the currently captured inputs.

Function
REQ-012 SHALL compute encrypted_message = (message mod n)^e mod n, with n = p*q held at 2*PQ_W bits.
REQ-013 SHALL use FSM states LOAD, REDUCE, EXP and DONE, and SHALL enter LOAD on reset release.
REQ-014 LOAD SHALL last 1 cycle: capture message, p, q and e; compute n; clear remainder r; go to REDUCE.
REQ-015 REDUCE SHALL last MSG_W cycles, one message bit per cycle, MSB first: r = 2r + bit, then subtract n if r >= n; then go to EXP.
REQ-016 EXP SHALL last E_W cycles of LSB-first square-and-multiply, with acc initialised to 1 mod n and base to r.
REQ-017 Each EXP cycle SHALL set acc = acc*base mod n when the current e bit is 1, and SHALL always set base = base*base mod n.
REQ-018 The 2*(2*PQ_W)-bit products SHALL be reduced mod n combinationally within the cycle.
REQ-019 On the last EXP edge, SHALL register acc into encrypted_message, set done=1 and go to DONE.
REQ-020 Total latency SHALL be 1+MSG_W+E_W = 75 rising edges from entering LOAD to done=1.
REQ-021 In DONE, if any live input differs from its captured value, SHALL clear done, go to LOAD, and hold encrypted_message until the new result is written.
REQ-022 Input changes during LOAD, REDUCE or EXP SHALL be ignored until DONE is reached.
REQ-023 If n < 2 (p or q equal to 0, or p=q=1), the result SHALL be 0.
REQ-024 If e = 0 and n >= 2, the result SHALL be 1.
REQ-025 If message mod n = 0 and e > 0, the result SHALL be 0.
REQ-026 Primality of p and q SHALL NOT be checked.

Reset
REQ-027 While rst=1, SHALL asynchronously force encrypted_message=0, done=0, state=LOAD, and clear all internal registers.
REQ-028 Reset asserted mid-operation SHALL abort the computation; after release, a fresh computation SHALL start from LOAD.

Configuration
REQ-029 With macro RSA_TOP_ERR_EN defined, SHALL add output err (1 bit), registered alongside done, high when the captured n < 2 and cleared by reset.
REQ-030 Without RSA_TOP_ERR_EN, port err SHALL NOT exist and all other behaviour SHALL be identical.

Verification
REQ-031 message=81799572057445, p=3, q=7, e=5, rst released -> done=1 after 75 edges, encrypted_message=16.
REQ-032 message=9, p=11, q=13, e=7 -> encrypted_message=48 (n=143).
REQ-033 message=2, p=3, q=11, e=0 -> encrypted_message=1; then, in DONE, e changes to 3 -> done drops next edge and encrypted_message=8 after 75 more edges.
REQ-034 p=0, q=7, any message, e=5 -> encrypted_message=0, and err=1 when RSA_TOP_ERR_EN is defined.
REQ-035 rst asserted during REDUCE -> encrypted_message=0 and done=0 immediately, with no clock needed; after release, the correct result arrives 75 edges later.
REQ-036 message changes mid-EXP -> the first result matches the old captured message; recomputation follows from DONE.
